// File: rtl/pulse_stretcher_pkg.sv
// Shared types and defaults for the pulse stretcher: FSM state encoding
// and the default length-counter width.
package pulse_stretcher_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into a level of LEN clock cycles, with
// optional retrigger, post-pulse hold-off, and completion/drop flags.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter bit RETRIGGER = 1'b0,
   parameter int GAP       = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN,
   input  logic [CNT_W-1:0] LEN,
   output logic             OUT,
   output logic             BUSY,
   output logic             DONE,
   output logic             DROP
);

   // Hold-off reload; only used when GAP > 0.
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP > 0) ? GAP - 1 : 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             len_ok;
   logic             retrig;

   assign len_ok = (LEN != '0);
   assign retrig = RETRIGGER && IN && len_ok;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         OUT   <= 1'b0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         DROP  <= 1'b0;
      end else begin
         DONE <= 1'b0;
         DROP <= 1'b0;
         case (state)
            IDLE: begin
               if (IN) begin
                  if (len_ok) begin
                     cnt   <= LEN - 1'b1;
                     OUT   <= 1'b1;
                     BUSY  <= 1'b1;
                     state <= ACTIVE;
                  end else begin
                     DROP <= 1'b1;
                  end
               end
            end

            ACTIVE: begin
               // A valid retrigger wins over expiry, so the level never dips.
               if (retrig) begin
                  cnt <= LEN - 1'b1;
               end else begin
                  if (IN) DROP <= 1'b1;
                  if (cnt == '0) begin
                     OUT  <= 1'b0;
                     DONE <= 1'b1;
                     if (GAP > 0) begin
                        cnt   <= GAP_LOAD;
                        state <= HOLDOFF;
                     end else begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                     end
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end

            HOLDOFF: begin
               if (IN) DROP <= 1'b1;
               if (cnt == '0) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               OUT   <= 1'b0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench: four stretcher configurations driven from a vector
// table and hand sequences; expected outputs flow through a scoreboard queue.
module tb_pulse_stretcher;

   typedef struct {
      int          sel;
      logic        rst;
      logic        in;
      logic [15:0] len;
      logic [3:0]  exp;   // {OUT, BUSY, DONE, DROP} after the sampling edge
      string       tag;
   } vec_t;

   logic             CLK;
   logic             rst;
   logic [3:0]       in_v;
   logic [2:0][15:0] len_v;
   logic [3:0]       len_s;
   logic [3:0]       out_v, busy_v, done_v, drop_v;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];
   vec_t sb[$];
   vec_t cur;
   logic [3:0] act;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // 0: no retrigger, no gap   1: retrigger   2: gap 3   3: 4-bit counter
   pulse_stretcher #(.CNT_W(16), .RETRIGGER(1'b0), .GAP(0)) u0 (
      .CLK(CLK), .RST(rst), .IN(in_v[0]), .LEN(len_v[0]),
      .OUT(out_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]), .DROP(drop_v[0]));
   pulse_stretcher #(.CNT_W(16), .RETRIGGER(1'b1), .GAP(0)) u1 (
      .CLK(CLK), .RST(rst), .IN(in_v[1]), .LEN(len_v[1]),
      .OUT(out_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]), .DROP(drop_v[1]));
   pulse_stretcher #(.CNT_W(16), .RETRIGGER(1'b0), .GAP(3)) u2 (
      .CLK(CLK), .RST(rst), .IN(in_v[2]), .LEN(len_v[2]),
      .OUT(out_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]), .DROP(drop_v[2]));
   pulse_stretcher #(.CNT_W(4), .RETRIGGER(1'b0), .GAP(0)) u3 (
      .CLK(CLK), .RST(rst), .IN(in_v[3]), .LEN(len_s),
      .OUT(out_v[3]), .BUSY(busy_v[3]), .DONE(done_v[3]), .DROP(drop_v[3]));

   function automatic void add(input int sel, input logic r, input logic i,
                               input logic [15:0] l, input logic [3:0] e,
                               input string tag, input int n = 1);
      vec_t v;
      v.sel = sel; v.rst = r; v.in = i; v.len = l; v.exp = e; v.tag = tag;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endfunction

   task automatic apply(input vec_t v);
      @(negedge CLK);
      rst  = v.rst;
      in_v = '0;
      in_v[v.sel] = v.in;
      if (v.sel == 3) len_s = v.len[3:0];
      else            len_v[v.sel] = v.len;
      sb.push_back(v);
   endtask

   task automatic drive(input int sel, input logic r, input logic i,
                        input logic [15:0] l, input logic [3:0] e,
                        input string tag, input int n = 1);
      vec_t v;
      v.sel = sel; v.rst = r; v.in = i; v.len = l; v.exp = e; v.tag = tag;
      for (int k = 0; k < n; k++) apply(v);
   endtask

   // Outputs settle just after the edge that sampled the matching inputs.
   always @(posedge CLK) begin
      #1;
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         act = {out_v[cur.sel], busy_v[cur.sel], done_v[cur.sel], drop_v[cur.sel]};
         checks++;
         if (act !== cur.exp) begin
            errors++;
            $display("FAIL %s (dut %0d) out/busy/done/drop got %b want %b",
                     cur.tag, cur.sel, act, cur.exp);
         end
      end
   end

   initial begin
      rst = 1'b1; in_v = '0; len_v = '0; len_s = '0;

      add(0, 1, 0, 0,  4'b0000, "reset", 10);
      // basic: LEN=5, LEN changes mid-pulse must be ignored
      add(0, 0, 1, 5,  4'b1100, "basic_trig");
      add(0, 0, 0, 9,  4'b1100, "basic_hi", 4);
      add(0, 0, 0, 9,  4'b0010, "basic_done");
      add(0, 0, 0, 0,  4'b0000, "basic_idle", 2);
      // retrigger 3 cycles after first, LEN=4 -> 7 high cycles
      add(1, 0, 1, 4,  4'b1100, "rt_trig1");
      add(1, 0, 0, 4,  4'b1100, "rt_hi", 2);
      add(1, 0, 1, 4,  4'b1100, "rt_trig2");
      add(1, 0, 0, 4,  4'b1100, "rt_hi2", 3);
      add(1, 0, 0, 4,  4'b0010, "rt_done");
      add(1, 0, 0, 4,  4'b0000, "rt_idle", 2);
      // same stimulus without retrigger
      add(0, 0, 1, 4,  4'b1100, "nrt_trig1");
      add(0, 0, 0, 4,  4'b1100, "nrt_hi", 2);
      add(0, 0, 1, 4,  4'b1101, "nrt_drop");
      add(0, 0, 0, 4,  4'b0010, "nrt_done");
      add(0, 0, 0, 4,  4'b0000, "nrt_idle", 3);
      // trigger on the expiry edge
      add(0, 0, 1, 2,  4'b1100, "exp0_trig");
      add(0, 0, 0, 2,  4'b1100, "exp0_hi");
      add(0, 0, 1, 2,  4'b0011, "exp0_done_drop");
      add(0, 0, 0, 2,  4'b0000, "exp0_idle");
      add(1, 0, 1, 2,  4'b1100, "exp1_trig");
      add(1, 0, 0, 2,  4'b1100, "exp1_hi");
      add(1, 0, 1, 2,  4'b1100, "exp1_ext");
      add(1, 0, 0, 2,  4'b1100, "exp1_hi2");
      add(1, 0, 0, 2,  4'b0010, "exp1_done");
      add(1, 0, 0, 2,  4'b0000, "exp1_idle");
      // hold-off GAP=3, LEN=2
      add(2, 0, 1, 2,  4'b1100, "ho_trig");
      add(2, 0, 0, 2,  4'b1100, "ho_hi");
      add(2, 0, 0, 2,  4'b0110, "ho_done");
      add(2, 0, 1, 2,  4'b0101, "ho_drop1");
      add(2, 0, 0, 2,  4'b0100, "ho_wait");
      add(2, 0, 1, 2,  4'b0001, "ho_drop3");
      add(2, 0, 1, 2,  4'b1100, "ho_trig4");
      add(2, 0, 0, 2,  4'b1100, "ho_hi4");
      add(2, 0, 0, 2,  4'b0110, "ho_done4");
      add(2, 0, 0, 2,  4'b0100, "ho_gap4", 2);
      add(2, 0, 0, 2,  4'b0000, "ho_idle", 2);
      // LEN=0 and LEN=1
      add(0, 0, 1, 0,  4'b0001, "len0_drop");
      add(0, 0, 0, 0,  4'b0000, "len0_idle");
      add(0, 0, 1, 1,  4'b1100, "len1_trig");
      add(0, 0, 0, 1,  4'b0010, "len1_done");
      add(0, 0, 0, 1,  4'b0000, "len1_idle");
      // GAP=0, trigger in the DONE cycle -> one low cycle
      add(0, 0, 1, 3,  4'b1100, "gap0_trig");
      add(0, 0, 0, 3,  4'b1100, "gap0_hi", 2);
      add(0, 0, 0, 3,  4'b0010, "gap0_done");
      add(0, 0, 1, 3,  4'b1100, "gap0_retrig");
      add(0, 0, 0, 3,  4'b1100, "gap0_hi2", 2);
      add(0, 0, 0, 3,  4'b0010, "gap0_done2");
      add(0, 0, 0, 3,  4'b0000, "gap0_idle");

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // IN held high, no retrigger: 2 on, 1 off, DROP on ignored cycles
      for (int p = 0; p < 2; p++) begin
         drive(0, 0, 1, 2, 4'b1100, "hold0_trig");
         drive(0, 0, 1, 2, 4'b1101, "hold0_drop");
         drive(0, 0, 1, 2, 4'b0011, "hold0_done");
      end
      drive(0, 0, 0, 2, 4'b0000, "hold0_idle");

      // IN held high with retrigger: continuous level
      drive(1, 0, 1, 2, 4'b1100, "hold1_hi", 5);
      drive(1, 0, 0, 2, 4'b1100, "hold1_tail");
      drive(1, 0, 0, 2, 4'b0010, "hold1_done");
      drive(1, 0, 0, 2, 4'b0000, "hold1_idle");

      // IN held high with GAP=3, LEN=1: 1 on, 1+3 off
      drive(2, 0, 1, 1, 4'b1100, "hold2_trig");
      drive(2, 0, 1, 1, 4'b0111, "hold2_done_drop");
      drive(2, 0, 1, 1, 4'b0101, "hold2_drop", 2);
      drive(2, 0, 1, 1, 4'b0001, "hold2_drop_end");
      drive(2, 0, 1, 1, 4'b1100, "hold2_retrig");
      drive(2, 0, 0, 1, 4'b0110, "hold2_done2");
      drive(2, 0, 0, 1, 4'b0100, "hold2_gap", 2);
      drive(2, 0, 0, 1, 4'b0000, "hold2_idle");

      // maximum length on a 4-bit counter
      drive(3, 0, 1, 15, 4'b1100, "max_trig");
      drive(3, 0, 0, 15, 4'b1100, "max_hi", 14);
      drive(3, 0, 0, 15, 4'b0010, "max_done");
      drive(3, 0, 0, 15, 4'b0000, "max_idle");

      // reset mid-pulse, reset dominant over a concurrent trigger
      drive(0, 0, 1, 20, 4'b1100, "rst_trig");
      drive(0, 0, 0, 20, 4'b1100, "rst_hi", 5);
      drive(0, 1, 1, 20, 4'b0000, "rst_trunc");
      drive(0, 0, 0, 20, 4'b0000, "rst_after", 2);
      drive(0, 0, 1, 20, 4'b1100, "rst_retrig");
      drive(0, 0, 0, 20, 4'b1100, "rst_hi2", 19);
      drive(0, 0, 0, 20, 4'b0010, "rst_done");
      drive(0, 0, 0, 20, 4'b0000, "rst_idle");

      for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge CLK);
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors never checked, want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
